instruction_fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined MIPS core. It owns the program counter, drives the combinational address input of the program ROM, and captures the returned word into the IF/ID pipeline register for the decode stage. It handles stall, flush, and branch/jump redirects from downstream stages, and keeps a running count of valid fetched instructions for debug.

---
 rtl/instruction_fetch_stage_if.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 54 +++++
 tb/tb_instruction_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: fetch-stage bus bundle (hazard/redirect controls, program-memory word, IF/ID outputs)
//   master: environment side (hazard unit, ID stage, program memory, decode consumer)
//   slave : the fetch stage itself
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall;
  logic                  Flush;
  logic                  BranchTaken;
  logic [DATA_WIDTH-1:0] BranchTarget;
  logic                  Jump;
  logic [DATA_WIDTH-1:0] JumpTarget;
  logic [DATA_WIDTH-1:0] Instruction;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] IF_ID_Instruction;
  logic [DATA_WIDTH-1:0] IF_ID_PCPlus4;
  logic                  IF_ID_Valid;
  logic [31:0]           FetchCount;
  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
    input  PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FetchCount
  );
  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
    output PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FetchCount
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage owning the PC and the IF/ID pipeline register
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of instruction_fetch_stage_if (controls, ROM word in; PC, IF/ID, FetchCount out)
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000
) (
  input logic                         clk,
  input logic                         reset,
  instruction_fetch_stage_if.slave    bus
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                  valid_q, valid_d;
  logic [31:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] pc_plus4, jump_tgt, branch_tgt;
  logic                  redirect, bubble, write_valid;
  always_comb begin
    pc_plus4    = pc_q + DATA_WIDTH'(4);
    jump_tgt    = {bus.JumpTarget[DATA_WIDTH-1:2], 2'b00};
    branch_tgt  = {bus.BranchTarget[DATA_WIDTH-1:2], 2'b00};
    redirect    = (bus.Jump | bus.BranchTaken) & ~bus.Stall;
    // wrong-path word at the old PC is squashed: no delay slot
    bubble      = bus.Flush | redirect;
    write_valid = ~bubble & ~bus.Stall;
    pc_d        = bus.Stall ? pc_q : bus.Jump ? jump_tgt : bus.BranchTaken ? branch_tgt : pc_plus4;
    instr_d     = bubble ? NOP_WORD : bus.Stall ? instr_q : bus.Instruction;
    pcp4_d      = bubble ? '0 : bus.Stall ? pcp4_q : pc_plus4;
    valid_d     = bubble ? 1'b0 : bus.Stall ? valid_q : 1'b1;
    count_d     = count_q + {31'b0, write_valid};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  assign bus.PC                = pc_q;
  assign bus.IF_ID_Instruction = instr_q;
  assign bus.IF_ID_PCPlus4     = pcp4_q;
  assign bus.IF_ID_Valid       = valid_q;
  assign bus.FetchCount        = count_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: table-driven directed checks of the IF stage with a combinational ROM model
module tb_instruction_fetch_stage;
  typedef struct {
    logic        st, fl, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt, pc, ins, p4;
    logic        v;
    logic [31:0] cnt;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus();
  instruction_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  assign bus.Instruction = rom(bus.PC);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic [31:0] cnt);
    chk({tag, "_pc"}, bus.PC, pc);
    chk({tag, "_ins"}, bus.IF_ID_Instruction, ins);
    chk({tag, "_p4"}, bus.IF_ID_PCPlus4, p4);
    chk({tag, "_valid"}, {31'b0, bus.IF_ID_Valid}, {31'b0, v});
    chk({tag, "_cnt"}, bus.FetchCount, cnt);
  endtask
  task automatic row(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [31:0] p4, input logic v, input logic [31:0] cnt);
    vec_t r;
    r = '{st, fl, br, bt, j, jt, pc, ins, p4, v, cnt};
    tbl.push_back(r);
  endtask
  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    bus.Stall = st; bus.Flush = fl; bus.BranchTaken = br;
    bus.BranchTarget = bt; bus.Jump = j; bus.JumpTarget = jt;
  endtask
  initial begin
    // sequential fetch W0..W3
    row(0, 0, 0, 0, 0, 0, 32'h0040_0004, rom(32'h0040_0000), 32'h0040_0004, 1, 1);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0008, rom(32'h0040_0004), 32'h0040_0008, 1, 2);
    row(0, 0, 0, 0, 0, 0, 32'h0040_000C, rom(32'h0040_0008), 32'h0040_000C, 1, 3);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0010, rom(32'h0040_000C), 32'h0040_0010, 1, 4);
    // branch redirect, one bubble, then target word
    row(0, 0, 1, 32'h0040_0020, 0, 0, 32'h0040_0020, 0, 0, 0, 4);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0024, rom(32'h0040_0020), 32'h0040_0024, 1, 5);
    // misaligned target forced to word boundary
    row(0, 0, 1, 32'h0040_0023, 0, 0, 32'h0040_0020, 0, 0, 0, 5);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0024, rom(32'h0040_0020), 32'h0040_0024, 1, 6);
    // stall masks jump for two edges
    row(1, 0, 0, 0, 1, 32'h0040_0100, 32'h0040_0024, rom(32'h0040_0020), 32'h0040_0024, 1, 6);
    row(1, 0, 0, 0, 1, 32'h0040_0100, 32'h0040_0024, rom(32'h0040_0020), 32'h0040_0024, 1, 6);
    row(0, 0, 0, 0, 1, 32'h0040_0100, 32'h0040_0100, 0, 0, 0, 6);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0104, rom(32'h0040_0100), 32'h0040_0104, 1, 7);
    // jump beats branch
    row(0, 0, 1, 32'h0040_0300, 1, 32'h0040_0200, 32'h0040_0200, 0, 0, 0, 7);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0204, rom(32'h0040_0200), 32'h0040_0204, 1, 8);
    // flush + stall: PC holds, bubble, then re-fetch held PC
    row(1, 1, 0, 0, 0, 0, 32'h0040_0204, 0, 0, 0, 8);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0208, rom(32'h0040_0204), 32'h0040_0208, 1, 9);
    // flush alone: PC still advances
    row(0, 1, 0, 0, 0, 0, 32'h0040_020C, 0, 0, 0, 9);
    row(0, 0, 0, 0, 0, 0, 32'h0040_0210, rom(32'h0040_020C), 32'h0040_0210, 1, 10);
    // PC wrap
    row(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0, 10);
    row(0, 0, 0, 0, 0, 0, 32'h0000_0000, rom(32'hFFFF_FFFC), 32'h0000_0000, 1, 11);
    // position at 0x0040_0040 for the async reset sequence
    row(0, 0, 0, 0, 1, 32'h0040_0040, 32'h0040_0040, 0, 0, 0, 11);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    chk_all("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'h0);
    #10 reset = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].ins, tbl[i].p4, tbl[i].v, tbl[i].cnt);
    end
    drive(0, 0, 0, 0, 0, 0);
    // async reset between edges, no clock edge before the check
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset", 32'h0040_0004, rom(32'h0040_0000), 32'h0040_0004, 1'b1, 32'h1);
    // FetchCount wrap
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    @(posedge clk);
    #1;
    chk_all("cnt_wrap", 32'h0040_0008, rom(32'h0040_0004), 32'h0040_0008, 1'b1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
